// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
//
// Shares one byte_sram between two single-byte requesters (port A, port B)
// using round-robin arbitration with a req/gnt handshake. The granted access
// is registered and presented to the SRAM in the following cycle. Read data is
// returned to the port that issued the read, RD_LATENCY cycles after the
// strobe, with a one-cycle rvalid pulse.
//
// Ports
//   sram_clk, sram_ares_n     clock (rising edge), async active-low reset
//   arb_en                    0 blocks new grants and freezes the pointer
//   a_req/a_we/a_addr/a_wdata port A request (held stable until a_gnt)
//   a_gnt                     port A request accepted this cycle (combinational)
//   a_rvalid/a_rdata          port A read return (rdata is 0 when not valid)
//   b_*                       same set for port B
//   wr_enable/rd_enable       registered SRAM strobes
//   ram_index/sram_data_in    registered SRAM address / write data
//   sram_data_out             SRAM read data
//   busy                      issue stage or any read return still pending
// -----------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              sram_clk,
  input  logic              sram_ares_n,
  input  logic              arb_en,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              wr_enable,
  output logic              rd_enable,
  output logic [ADDR_W-1:0] ram_index,
  output logic [DATA_W-1:0] sram_data_in,
  input  logic [DATA_W-1:0] sram_data_out,
  output logic              busy
);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  port_e                  prio;      // port that wins when both request
  port_e                  iss_port;  // owner of the access in the issue stage
  logic [RD_LATENCY-1:0]  tag_v;     // read-return tags, index 0 is youngest
  port_e                  tag_p [RD_LATENCY];

  logic                   any_gnt;
  logic                   sel_we;
  logic [ADDR_W-1:0]      sel_addr;
  logic [DATA_W-1:0]      sel_wdata;

  // Grant decision. Gating with the reset keeps gnt low while reset is held,
  // even though requests may already be present.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (sram_ares_n && arb_en) begin
      if (a_req && (!b_req || prio == PORT_A)) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
    end
  end

  assign any_gnt   = a_gnt | b_gnt;
  assign sel_we    = b_gnt ? b_we    : a_we;
  assign sel_addr  = b_gnt ? b_addr  : a_addr;
  assign sel_wdata = b_gnt ? b_wdata : a_wdata;

  // Issue stage: the granted access drives the SRAM in the next cycle.
  always_ff @(posedge sram_clk or negedge sram_ares_n) begin
    if (!sram_ares_n) begin
      prio         <= PORT_A;
      iss_port     <= PORT_A;
      wr_enable    <= 1'b0;
      rd_enable    <= 1'b0;
      ram_index    <= '0;
      sram_data_in <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its pre-edge inputs regardless of statement order.
      wr_enable <= any_gnt &  sel_we;
      rd_enable <= any_gnt & ~sel_we;
      if (any_gnt) begin
        ram_index <= sel_addr;
        iss_port  <= b_gnt ? PORT_B : PORT_A;
        // The port just served loses the next tie.
        prio      <= a_gnt ? PORT_B : PORT_A;
      end
      if (any_gnt && sel_we) begin
        sram_data_in <= sel_wdata;
      end
    end
  end

  // Read-return tags travel alongside the SRAM latency. Reset clears them so
  // reads in flight at reset never produce rvalid.
  always_ff @(posedge sram_clk or negedge sram_ares_n) begin
    if (!sram_ares_n) begin
      tag_v <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_p[i] <= PORT_A;
      end
    end else begin
      tag_v[0] <= rd_enable;
      tag_p[0] <= iss_port;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_p[i] <= tag_p[i-1];
      end
    end
  end

  assign a_rvalid = tag_v[RD_LATENCY-1] && (tag_p[RD_LATENCY-1] == PORT_A);
  assign b_rvalid = tag_v[RD_LATENCY-1] && (tag_p[RD_LATENCY-1] == PORT_B);
  assign a_rdata  = a_rvalid ? sram_data_out : '0;
  assign b_rdata  = b_rvalid ? sram_data_out : '0;
  assign busy     = wr_enable | rd_enable | (|tag_v);

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
Two-requester round-robin arbiter that shares one byte_sram instance between port A and port B. It accepts single-byte read/write requests with a req/gnt handshake and drives the SRAM strobes from registers. It routes read data back to the originating port with a valid pulse. It sits directly in front of byte_sram, and its SRAM-side ports connect by name.

Parameters:
ADDR_W  7  SRAM address width (ram_index)
DATA_W  8  SRAM data width
RD_LATENCY  1  cycles from the SRAM clock edge that samples rd_enable to valid sram_data_out; legal range 1..4

Ports:
sram_clk  input  1  clock, rising edge
sram_ares_n  input  1  reset, asynchronous assert, active-low
arb_en  input  1  1 = arbitration enabled; 0 = no new grants
a_req  input  1  port A request valid
a_we  input  1  port A 1 = write, 0 = read
a_addr  input  ADDR_W  port A address
a_wdata  input  DATA_W  port A write data
a_gnt  output  1  port A request accepted this cycle
a_rvalid  output  1  port A read data valid
a_rdata  output  DATA_W  port A read data
b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata  same as port A, for port B
wr_enable  output  1  SRAM write strobe
rd_enable  output  1  SRAM read strobe
ram_index  output  ADDR_W  SRAM address
sram_data_in  output  DATA_W  SRAM write data
sram_data_out  input  DATA_W  SRAM read data
busy  output  1  1 while any access is issued or any read is in flight

Behaviour:
- Reset (sram_ares_n = 0) forces all outputs to 0 immediately: gnt, rvalid, rdata, wr_enable, rd_enable, ram_index, sram_data_in, busy. The priority pointer resets to A.
- Reset mid-operation: in-flight reads are discarded and no rvalid is ever produced for them. After release, the first grant is evaluated on the first clock edge.
- Grant is combinational in cycle t. gnt_x = req_x & arb_en & (selected by arbitration). At most one gnt per cycle.
- Arbitration:
  - Only one port requesting: that port is granted every cycle, with no bubbles.
  - Both ports requesting: the port not granted last wins. The pointer updates only on a grant.
  - arb_en = 0: no grants, and the pointer is held.
- A request is consumed only when req & gnt are both high. A requester holds req, we, addr and wdata stable until it is granted.
- Issue: the granted transaction is registered at the cycle t edge, and the SRAM sees it in cycle t+1:
  - write: wr_enable = 1, ram_index = addr, sram_data_in = wdata
  - read: rd_enable = 1, ram_index = addr
  - wr_enable and rd_enable are never both 1 and are 0 when there was no grant.
  - sram_data_in holds its last value when not writing.
- Read return:
  - A tag shift register of depth RD_LATENCY records {valid, port}.
  - The owning port's rvalid = 1 in cycle t+1+RD_LATENCY, with rdata = sram_data_out (combinational pass-through).
  - The non-owning port's rvalid = 0. rdata holds 0 when rvalid = 0.
- Ordering: accesses reach the SRAM in grant order, so a write followed by a read of the same address returns the new data. Read returns come in issue order, with at most one per cycle.
- Throughput: one access per cycle sustained. Reads and writes can be interleaved back to back without stalls, and writes never produce rvalid.
- busy = issue stage valid OR any tag valid. busy is 0 only when the pipeline is fully drained.

Test Plan:
- Reset then idle: sram_ares_n low for 3 cycles, then high, no req → all outputs 0; no strobe for 10 cycles.
- A writes 0x5A to 0x10, then reads 0x10 (RD_LATENCY = 1) → wr_enable in cycle t+1; read granted at t+1, rd_enable at t+2; a_rvalid = 1 with a_rdata = 0x5A at t+3; b_rvalid stays 0.
- A and B both hold req for 6 cycles → grants alternate A, B, A, B, A, B; each port gets exactly 3 grants.
- B alone holds req for 5 reads of 0x00..0x04 (preloaded 0xF0..0xF4) → 5 consecutive gnts; b_rvalid high for 5 consecutive cycles with data 0xF0..0xF4 in order.
- Reset asserted the cycle after a read grant → rd_enable drops immediately; no rvalid afterward; the next grant after release goes to A.
- arb_en = 0 while both ports request for 4 cycles → no gnt and no strobes. Raising arb_en → the first grant goes to the pointer's port (A after reset).
